// File: rtl/mult_sweep_pkg.sv
// Shared types and constants for the 8x8 multiplier sweep checker.
// The first-fail capture is enabled with MULT_SWEEP_FIRST_FAIL_EN.
package mult_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 17;
    localparam int SUM_W  = 32;

    localparam logic [PROD_W-1:0] LAST_IDX = 16'hFFFF;

    function automatic logic [PROD_W-1:0] abs_diff(input logic [PROD_W-1:0] x,
                                                   input logic [PROD_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/mult_sweep_delay.sv
// Operand/valid delay line that lines the issued pair up with the DUT product.
// Zero stages collapse to a straight wire.
module mult_sweep_delay #(
    parameter int unsigned PIPE_LAT = 0,
    parameter int unsigned W        = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    if (PIPE_LAT == 0) begin : g_wire
        logic w_unused_clk;
        assign w_unused_clk = clk ^ rst_n;
        assign o_data       = i_data;
    end else begin : g_pipe
        logic [W-1:0] r_pipe [PIPE_LAT];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < PIPE_LAT; i++) r_pipe[i] <= '0;
            end else begin
                r_pipe[0] <= i_data;
                for (int i = 1; i < PIPE_LAT; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign o_data = r_pipe[PIPE_LAT-1];
    end

endmodule

// File: rtl/mult8_sweep_checker.sv
// Exhaustive sweep of all 8x8 operand pairs with error statistics on the DUT product.
// Define MULT_SWEEP_FIRST_FAIL_EN to add capture of the first mismatching pair.
module mult8_sweep_checker
    import mult_sweep_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [OP_W-1:0]   dut_a,
    output logic [OP_W-1:0]   dut_b,
    input  logic [PROD_W-1:0] dut_p,
    output logic [CNT_W-1:0]  err_count,
    output logic [PROD_W-1:0] max_abs_err,
    output logic [SUM_W-1:0]  sum_abs_err,
    output state_t            o_dbg_state
`ifdef MULT_SWEEP_FIRST_FAIL_EN
    ,
    output logic              first_fail_valid,
    output logic [OP_W-1:0]   first_fail_a,
    output logic [OP_W-1:0]   first_fail_b
`endif
);

    localparam int unsigned   DLY_W      = 1 + 2 * OP_W;
    localparam logic [15:0]   DRAIN_LAST = 16'(PIPE_LAT - 1);

    // Protocol: start is a one-cycle request honoured only in IDLE; done is a
    // one-cycle pulse and the statistics are final while it is high.
    state_t              r_state;
    logic [PROD_W-1:0]   r_idx;
    logic [15:0]         r_drain;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_cnt;
    logic [PROD_W-1:0]   r_max;
    logic [SUM_W-1:0]    r_sum;

    logic                w_start_acc;
    logic [DLY_W-1:0]    w_dly_in;
    logic [DLY_W-1:0]    w_dly_out;
    logic                w_chk_valid;
    logic [PROD_W-1:0]   w_exp;
    logic [PROD_W-1:0]   w_err;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_dly_in    = {(r_state == ST_SWEEP), r_idx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SWEEP;
                        r_idx   <= '0;
                        r_drain <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (r_idx == LAST_IDX) begin
                        // Operands stay at 0xFF/0xFF through DRAIN.
                        if (PIPE_LAT > 0) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state <= ST_DONE;
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_idx <= r_idx + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= ST_DONE;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 16'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    mult_sweep_delay #(
        .PIPE_LAT (PIPE_LAT),
        .W        (DLY_W)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (w_dly_in),
        .o_data (w_dly_out)
    );

    assign w_chk_valid = w_dly_out[DLY_W-1];
    assign w_exp       = {8'b0, w_dly_out[15:8]} * {8'b0, w_dly_out[7:0]};
    assign w_err       = abs_diff(dut_p, w_exp);

`ifdef MULT_SWEEP_FIRST_FAIL_EN
    logic            r_ff_valid;
    logic [OP_W-1:0] r_ff_a;
    logic [OP_W-1:0] r_ff_b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_max <= '0;
            r_sum <= '0;
`ifdef MULT_SWEEP_FIRST_FAIL_EN
            r_ff_valid <= 1'b0;
            r_ff_a     <= '0;
            r_ff_b     <= '0;
`endif
        end else if (w_start_acc) begin
            r_cnt <= '0;
            r_max <= '0;
            r_sum <= '0;
`ifdef MULT_SWEEP_FIRST_FAIL_EN
            r_ff_valid <= 1'b0;
            r_ff_a     <= '0;
            r_ff_b     <= '0;
`endif
        end else if (w_chk_valid && (w_err != '0)) begin
            r_cnt <= r_cnt + 17'd1;
            r_sum <= r_sum + {16'b0, w_err};
            if (w_err > r_max) r_max <= w_err;
`ifdef MULT_SWEEP_FIRST_FAIL_EN
            if (!r_ff_valid) begin
                r_ff_valid <= 1'b1;
                r_ff_a     <= w_dly_out[15:8];
                r_ff_b     <= w_dly_out[7:0];
            end
`endif
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign dut_a       = r_idx[15:8];
    assign dut_b       = r_idx[7:0];
    assign err_count   = r_cnt;
    assign max_abs_err = r_max;
    assign sum_abs_err = r_sum;
    assign o_dbg_state = r_state;

`ifdef MULT_SWEEP_FIRST_FAIL_EN
    assign first_fail_valid = r_ff_valid;
    assign first_fail_a     = r_ff_a;
    assign first_fail_b     = r_ff_b;
`endif

endmodule

// File: doc/mult8_sweep_checker.md
# mult8_sweep_checker

Exhaustive self-checking harness block for the 8x8 multipliers built from 4x4 sub-multipliers. It drives every operand pair into the multiplier under test (DUT) and consumes the DUT product. Each product is compared against the exact A*B, and the block accumulates error statistics: mismatch count, maximum absolute error, and sum of absolute errors. These statistics are the hardware-side input to the RL reward and scoring flow for candidate multiplier architectures.

## Interface
- `PIPE_LAT`, default 0: DUT latency in clock cycles from operands to product (0 means a combinational DUT).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: single-cycle request to begin a sweep; accepted only in IDLE.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `done` output 1: one-cycle pulse when all statistics are final.
- `dut_a` output 8: operand A driven to the DUT.
- `dut_b` output 8: operand B driven to the DUT.
- `dut_p` input 16: DUT product, valid `PIPE_LAT` cycles after the operands.
- `err_count` output 17: number of pairs with `dut_p` != A*B (0 to 65536).
- `max_abs_err` output 16: largest value of |dut_p − A*B| seen.
- `sum_abs_err` output 32: sum of |dut_p − A*B| over all checked pairs.

## Operation
- **FSM states:** IDLE, SWEEP, DRAIN, DONE. Encoding is defined in the package.
- **IDLE:** `dut_a`/`dut_b` are held at 0.
  - `start`=1 moves to SWEEP.
  - `start` also clears all statistics and the operand index.
- **SWEEP:** 16-bit index = {`dut_a`,`dut_b`}; `dut_b` is the fast digit.
  - Index 0x0000 is issued on the first SWEEP cycle; the index increments by one each cycle.
  - After 0xFFFF is issued, the FSM goes to DRAIN if `PIPE_LAT`>0, otherwise to DONE.
- **DRAIN:** operands are held at 0xFF/0xFF. Stays for `PIPE_LAT` cycles, then goes to DONE.
- **DONE:** `done`=1 for exactly one cycle, then back to IDLE.
- **Statistics** hold their values in IDLE until the next accepted `start`.
- **Check pipeline:** a delay line `PIPE_LAT` deep carries {valid, a, b}, aligned with `dut_p`.
  - When delayed valid=1: exp = a*b (unsigned, 16 bit); err = |dut_p − exp| (16-bit unsigned).
  - If err≠0: `err_count`+=1, `sum_abs_err`+=err, `max_abs_err`=max(`max_abs_err`, err).
- **Widths:** no statistic can overflow. The maximum possible sum is 65536·65535 < 2^32, so no saturation logic is needed.
- **`start` while busy:** ignored.
- **Reset:** asserting `rst_n`=0 at any time, including mid-sweep, aborts the sweep. Every output and the delay line return to reset values.

## Timing
- **Reset values:** `busy`=0, `done`=0, `dut_a`=0, `dut_b`=0, `err_count`=0, `max_abs_err`=0, `sum_abs_err`=0, state=IDLE.
- **Start to first operand:** `start` is sampled at edge 0; SWEEP and operands 0/0 begin after edge 0.
- **Sweep length:** 65536 SWEEP cycles plus `PIPE_LAT` DRAIN cycles.
- **`done` timing:** `done` rises after edge 65536+`PIPE_LAT`. The statistics are final in that same cycle.
- **Statistics registers** update one edge after their `dut_p` sample.

## Configuration
- **`MULT_SWEEP_FIRST_FAIL_EN` defined:** adds outputs `first_fail_valid` (1), `first_fail_a` (8), `first_fail_b` (8).
  - They capture the operands of the first mismatching pair of a sweep.
  - Valid stays sticky until the next `start` or reset; reset value is 0/0/0.
- **Not defined:** these ports and their registers do not exist.

## Structure
- **Package `mult_sweep_pkg`** holds:
  - the state enum (IDLE/SWEEP/DRAIN/DONE);
  - the constants OP_W=8, PROD_W=16, CNT_W=17, SUM_W=32;
  - the last-index constant 16'hFFFF.
- **Sub-module `mult_sweep_delay`:** a parameterised shift register of `PIPE_LAT` stages carrying {valid, a, b}. It reduces to wires when `PIPE_LAT`=0, and has an async active-low clear.
- **Top level** contains the FSM, the index counter, the exact-product reference, and the statistics accumulators.

## Test plan
- **Exact combinational DUT, `PIPE_LAT`=0:** pulse `start` → `done` after 65536 cycles; `err_count`=0, `max_abs_err`=0, `sum_abs_err`=0.
- **DUT exact except bit 0 flipped at A=3, B=5:** → `err_count`=1, `max_abs_err`=1, `sum_abs_err`=1. With the macro defined: `first_fail_a`=3, `first_fail_b`=5.
- **DUT with `dut_p` tied to 0:** → `err_count`=65025, `max_abs_err`=65025, `sum_abs_err`=1065369600.
- **`PIPE_LAT`=2 with a 2-register exact DUT:** → zero errors; `done` arrives exactly 2 cycles later than in the combinational case.
- **Reset mid-sweep:** assert `rst_n` low at index 0x1234 with error injection active → all outputs return to 0 immediately. A fresh `start` then gives clean results.
- **`start` pulsed again mid-sweep:** → ignored; index continues, `done` timing and statistics are unchanged.
